src_control_unit: RTL and testbench

Hardwired timing-step controller for the SRC bus CPU. Consumes the 5-bit opcode from the instruction register, plus the branch-condition and memory-done flags. Sequences fetch and execute steps T0–T7 and drives every register/ALU/memory control strobe on the shared bus datapath, including IRin, c1out and c2out toward the instruction register. It is the consumer of `to_control_unit` and the producer of IR's `IRin/c1/c2` inputs.

---
 rtl/src_cu_pkg.sv | 88 ++++++++
 rtl/src_cu_if.sv | 33 +++
 rtl/src_cu_decode.sv | 89 ++++++++
 rtl/src_control_unit.sv | 98 +++++++++
 tb/tb_src_control_unit.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/src_cu_pkg.sv
// Shared types for the SRC hardwired control unit: control-strobe bundle,
// T-step state encoding, opcode values and opcode-class helpers.
package src_cu_pkg;

    localparam int OPW = 5;

    typedef struct packed {
        logic       PCout;
        logic       PCin;
        logic       MAin;
        logic       INC4;
        logic       Cin;
        logic       Cout;
        logic       Ain;
        logic       Read;
        logic       Write;
        logic       Wait;
        logic       MDout;
        logic       MDbus;
        logic       IRin;
        logic       c1out;
        logic       c2out;
        logic       Gra;
        logic       Grb;
        logic       Grc;
        logic       Rout;
        logic       Rin;
        logic       BAout;
        logic       CONin;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam logic [OPW-1:0] OP_NOP  = 5'd0;
    localparam logic [OPW-1:0] OP_LD   = 5'd1;
    localparam logic [OPW-1:0] OP_ST   = 5'd3;
    localparam logic [OPW-1:0] OP_LA   = 5'd5;
    localparam logic [OPW-1:0] OP_BR   = 5'd8;
    localparam logic [OPW-1:0] OP_ADD  = 5'd12;
    localparam logic [OPW-1:0] OP_ADDI = 5'd13;
    localparam logic [OPW-1:0] OP_SUB  = 5'd14;
    localparam logic [OPW-1:0] OP_AND  = 5'd20;
    localparam logic [OPW-1:0] OP_OR   = 5'd22;
    localparam logic [OPW-1:0] OP_STOP = 5'd31;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    // Bit 3 is the "running" flag and bits 2:0 are the T-step index.
    typedef enum logic [3:0] {
        S_HALT = 4'b0000,
        S_T0   = 4'b1000,
        S_T1   = 4'b1001,
        S_T2   = 4'b1010,
        S_T3   = 4'b1011,
        S_T4   = 4'b1100,
        S_T5   = 4'b1101,
        S_T6   = 4'b1110,
        S_T7   = 4'b1111
    } state_e;

    function automatic logic is_alu_op(input logic [OPW-1:0] op);
        return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_SUB) ||
               (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic is_addr_op(input logic [OPW-1:0] op);
        return (op == OP_LA) || (op == OP_LD) || (op == OP_ST);
    endfunction

    function automatic logic is_defined(input logic [OPW-1:0] op);
        return is_alu_op(op) || is_addr_op(op) || (op == OP_BR) ||
               (op == OP_NOP) || (op == OP_STOP);
    endfunction

    function automatic logic [1:0] alu_sel(input logic [OPW-1:0] op);
        logic [1:0] sel;
        case (op)
            OP_SUB:  sel = ALU_SUB;
            OP_AND:  sel = ALU_AND;
            OP_OR:   sel = ALU_OR;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/src_cu_if.sv
// Opcode/flag inputs and strobe/status outputs of the control unit.
// The illegal flag exists only when SRC_CU_ILLEGAL_TRAP_EN is defined.
interface src_cu_if;
    import src_cu_pkg::*;

    logic [OPW-1:0] opcode;
    logic           start;
    logic           con;
    logic           mem_done;
    ctrl_t          ctrl;
    logic           run;
    logic [2:0]     step;
`ifdef SRC_CU_ILLEGAL_TRAP_EN
    logic           illegal;
`endif

    modport master (
        output opcode, start, con, mem_done,
`ifdef SRC_CU_ILLEGAL_TRAP_EN
        input  illegal,
`endif
        input  ctrl, run, step
    );

    modport slave (
        input  opcode, start, con, mem_done,
`ifdef SRC_CU_ILLEGAL_TRAP_EN
        output illegal,
`endif
        output ctrl, run, step
    );

endinterface

// File: rtl/src_cu_decode.sv
// Pure combinational strobe decode from (T-step, opcode); con only gates
// the conditional PCin of a branch.
module src_cu_decode
    import src_cu_pkg::*;
(
    input  state_e         i_state,
    input  logic [OPW-1:0] i_opcode,
    input  logic           i_con,
    output ctrl_t          o_ctrl
);

    // Strobe table per step; anything not named stays low.
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_T0: begin
                o_ctrl.PCout = 1'b1; o_ctrl.MAin = 1'b1;
                o_ctrl.INC4  = 1'b1; o_ctrl.Cin  = 1'b1;
            end
            S_T1: begin
                o_ctrl.Read = 1'b1; o_ctrl.Cout = 1'b1;
                o_ctrl.PCin = 1'b1; o_ctrl.Wait = 1'b1;
            end
            S_T2: begin
                o_ctrl.MDout = 1'b1; o_ctrl.IRin = 1'b1;
            end
            S_T3: begin
                if (is_alu_op(i_opcode)) begin
                    o_ctrl.Grb = 1'b1; o_ctrl.Rout = 1'b1; o_ctrl.Ain = 1'b1;
                end else if (is_addr_op(i_opcode)) begin
                    o_ctrl.Grb = 1'b1; o_ctrl.BAout = 1'b1; o_ctrl.Ain = 1'b1;
                end else if (i_opcode == OP_BR) begin
                    o_ctrl.Grc = 1'b1; o_ctrl.Rout = 1'b1; o_ctrl.CONin = 1'b1;
                end else begin
                    o_ctrl = '0;
                end
            end
            S_T4: begin
                if (is_alu_op(i_opcode)) begin
                    if (i_opcode == OP_ADDI) begin
                        o_ctrl.c2out = 1'b1;
                    end else begin
                        o_ctrl.Grc = 1'b1; o_ctrl.Rout = 1'b1;
                    end
                    o_ctrl.alu_op = alu_sel(i_opcode);
                    o_ctrl.Cin    = 1'b1;
                end else if (is_addr_op(i_opcode)) begin
                    o_ctrl.c2out  = 1'b1;
                    o_ctrl.alu_op = ALU_ADD;
                    o_ctrl.Cin    = 1'b1;
                end else if (i_opcode == OP_BR) begin
                    o_ctrl.Grb  = 1'b1; o_ctrl.Rout = 1'b1;
                    o_ctrl.PCin = i_con;
                end else begin
                    o_ctrl = '0;
                end
            end
            S_T5: begin
                if (is_alu_op(i_opcode) || (i_opcode == OP_LA)) begin
                    o_ctrl.Cout = 1'b1; o_ctrl.Gra = 1'b1; o_ctrl.Rin = 1'b1;
                end else if ((i_opcode == OP_LD) || (i_opcode == OP_ST)) begin
                    o_ctrl.Cout = 1'b1; o_ctrl.MAin = 1'b1;
                end else begin
                    o_ctrl = '0;
                end
            end
            S_T6: begin
                if (i_opcode == OP_LD) begin
                    o_ctrl.Read = 1'b1; o_ctrl.Wait = 1'b1;
                end else if (i_opcode == OP_ST) begin
                    o_ctrl.Gra = 1'b1; o_ctrl.Rout = 1'b1; o_ctrl.MDbus = 1'b1;
                end else begin
                    o_ctrl = '0;
                end
            end
            S_T7: begin
                if (i_opcode == OP_LD) begin
                    o_ctrl.MDout = 1'b1; o_ctrl.Gra = 1'b1; o_ctrl.Rin = 1'b1;
                end else if (i_opcode == OP_ST) begin
                    o_ctrl.Write = 1'b1; o_ctrl.Wait = 1'b1;
                end else begin
                    o_ctrl = '0;
                end
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/src_control_unit.sv
// SRC hardwired timing-step controller: HALT plus T0..T7 sequencing.
// Optional trap on undefined opcodes via SRC_CU_ILLEGAL_TRAP_EN.
module src_control_unit
    import src_cu_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    src_cu_if.slave bus
);

    state_e r_state;
    state_e w_next;
    ctrl_t  w_ctrl;

    // State register; reset abandons any step, including a pending handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_HALT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: wait steps hold until mem_done, execute path depends on opcode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HALT: if (bus.start) w_next = S_T0; else w_next = S_HALT;
            S_T0:   w_next = S_T1;
            S_T1:   if (bus.mem_done) w_next = S_T2; else w_next = S_T1;
            S_T2:   w_next = S_T3;
            S_T3: begin
                if (bus.opcode == OP_STOP) begin
                    w_next = S_HALT;
                end else if (bus.opcode == OP_NOP) begin
                    w_next = S_T0;
                end else if (is_defined(bus.opcode)) begin
                    w_next = S_T4;
                end else begin
`ifdef SRC_CU_ILLEGAL_TRAP_EN
                    w_next = S_HALT;
`else
                    w_next = S_T0;
`endif
                end
            end
            S_T4: if (bus.opcode == OP_BR) w_next = S_T0; else w_next = S_T5;
            S_T5: begin
                if ((bus.opcode == OP_LD) || (bus.opcode == OP_ST)) w_next = S_T6;
                else w_next = S_T0;
            end
            S_T6: begin
                if ((bus.opcode == OP_LD) && !bus.mem_done) w_next = S_T6;
                else w_next = S_T7;
            end
            S_T7: begin
                if ((bus.opcode == OP_ST) && !bus.mem_done) w_next = S_T7;
                else w_next = S_T0;
            end
            default: w_next = S_HALT;
        endcase
    end

    src_cu_decode u_decode (
        .i_state  (r_state),
        .i_opcode (bus.opcode),
        .i_con    (bus.con),
        .o_ctrl   (w_ctrl)
    );

`ifdef SRC_CU_ILLEGAL_TRAP_EN
    logic r_illegal;

    // Sticky trap flag: set on an undefined opcode at T3, cleared by restart.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_illegal <= 1'b0;
        end else if ((r_state == S_HALT) && bus.start) begin
            r_illegal <= 1'b0;
        end else if ((r_state == S_T3) && !is_defined(bus.opcode)) begin
            r_illegal <= 1'b1;
        end else begin
            r_illegal <= r_illegal;
        end
    end
`endif

    // Outputs: run/step straight from the state encoding, strobes from decode.
    always_comb begin
        bus.ctrl = w_ctrl;
        bus.run  = r_state[3];
        bus.step = r_state[2:0];
`ifdef SRC_CU_ILLEGAL_TRAP_EN
        bus.illegal = r_illegal;
`endif
    end

endmodule

// File: tb/tb_src_control_unit.sv
// Bench for src_control_unit: instruction-level reference model plus
// directed literal checks, then randomized opcode/handshake stimulus.
module tb_src_control_unit;
    import src_cu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    src_cu_if bus();

    src_control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    step;
        ctrl_t c;
        bit    wt;
        bit    brpc;
        bit    hlt;
        bit    ill;
    } ent_t;

    ent_t m_q[$];
    bit   m_halted = 1'b1;
    bit   m_ill    = 1'b0;

    logic [4:0] ops [14] = '{5'd0, 5'd1, 5'd3, 5'd5, 5'd8, 5'd12, 5'd13,
                             5'd14, 5'd20, 5'd22, 5'd31, 5'd7, 5'd2, 5'd30};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int st, input ctrl_t c, input bit wt, input bit brpc,
                        input bit hlt, input bit ill);
        ent_t e;
        e.step = st; e.c = c; e.wt = wt; e.brpc = brpc; e.hlt = hlt; e.ill = ill;
        m_q.push_back(e);
    endtask

    task automatic push_fetch();
        ctrl_t c;
        c = '0; c.PCout = 1'b1; c.MAin = 1'b1; c.INC4 = 1'b1; c.Cin = 1'b1;
        push(0, c, 1'b0, 1'b0, 1'b0, 1'b0);
        c = '0; c.Read = 1'b1; c.Cout = 1'b1; c.PCin = 1'b1; c.Wait = 1'b1;
        push(1, c, 1'b1, 1'b0, 1'b0, 1'b0);
        c = '0; c.MDout = 1'b1; c.IRin = 1'b1;
        push(2, c, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Execute steps of one instruction, written from the instruction table.
    task automatic push_exec(input logic [4:0] op);
        ctrl_t c;
        case (op)
            5'd12, 5'd13, 5'd14, 5'd20, 5'd22: begin
                c = '0; c.Grb = 1'b1; c.Rout = 1'b1; c.Ain = 1'b1;
                push(3, c, 1'b0, 1'b0, 1'b0, 1'b0);
                c = '0; c.Cin = 1'b1;
                if (op == 5'd13) c.c2out = 1'b1;
                else begin c.Grc = 1'b1; c.Rout = 1'b1; end
                c.alu_op = (op == 5'd14) ? 2'd1 : (op == 5'd20) ? 2'd2 :
                           (op == 5'd22) ? 2'd3 : 2'd0;
                push(4, c, 1'b0, 1'b0, 1'b0, 1'b0);
                c = '0; c.Cout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1;
                push(5, c, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            5'd5, 5'd1, 5'd3: begin
                c = '0; c.Grb = 1'b1; c.BAout = 1'b1; c.Ain = 1'b1;
                push(3, c, 1'b0, 1'b0, 1'b0, 1'b0);
                c = '0; c.c2out = 1'b1; c.Cin = 1'b1;
                push(4, c, 1'b0, 1'b0, 1'b0, 1'b0);
                c = '0; c.Cout = 1'b1;
                if (op == 5'd5) begin c.Gra = 1'b1; c.Rin = 1'b1; end
                else c.MAin = 1'b1;
                push(5, c, 1'b0, 1'b0, 1'b0, 1'b0);
                if (op == 5'd1) begin
                    c = '0; c.Read = 1'b1; c.Wait = 1'b1;
                    push(6, c, 1'b1, 1'b0, 1'b0, 1'b0);
                    c = '0; c.MDout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1;
                    push(7, c, 1'b0, 1'b0, 1'b0, 1'b0);
                end else if (op == 5'd3) begin
                    c = '0; c.Gra = 1'b1; c.Rout = 1'b1; c.MDbus = 1'b1;
                    push(6, c, 1'b0, 1'b0, 1'b0, 1'b0);
                    c = '0; c.Write = 1'b1; c.Wait = 1'b1;
                    push(7, c, 1'b1, 1'b0, 1'b0, 1'b0);
                end
            end
            5'd8: begin
                c = '0; c.Grc = 1'b1; c.Rout = 1'b1; c.CONin = 1'b1;
                push(3, c, 1'b0, 1'b0, 1'b0, 1'b0);
                c = '0; c.Grb = 1'b1; c.Rout = 1'b1;
                push(4, c, 1'b0, 1'b1, 1'b0, 1'b0);
            end
            5'd0:  push(3, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            5'd31: push(3, '0, 1'b0, 1'b0, 1'b1, 1'b0);
            default: begin
`ifdef SRC_CU_ILLEGAL_TRAP_EN
                push(3, '0, 1'b0, 1'b0, 1'b1, 1'b1);
`else
                push(3, '0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
            end
        endcase
    endtask

    // Reference model advance: one queue entry per cycle, wait entries stall.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_halted = 1'b1;
            m_ill    = 1'b0;
        end else if (m_halted) begin
            if (bus.start) begin
                m_halted = 1'b0;
                m_ill    = 1'b0;
                push_fetch();
            end
        end else if (m_q.size() > 0) begin
            ent_t e;
            e = m_q[0];
            if (!(e.wt && !bus.mem_done)) begin
                void'(m_q.pop_front());
                if (e.step == 2) push_exec(bus.opcode);
                if (m_q.size() == 0) begin
                    if (e.hlt) begin
                        m_halted = 1'b1;
                        if (e.ill) m_ill = 1'b1;
                    end else begin
                        push_fetch();
                    end
                end
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always begin
        @(negedge clk);
        #1;
        if (rst === 1'b1) begin
            ctrl_t ec;
            logic  er;
            int    es;
            if (m_halted || (m_q.size() == 0)) begin
                ec = '0; er = 1'b0; es = 0;
            end else begin
                ec = m_q[0].c;
                if (m_q[0].brpc) ec.PCin = bus.con;
                er = 1'b1;
                es = m_q[0].step;
            end
            chk("model_ctrl", 32'(bus.ctrl), 32'(ec));
            chk("model_run", 32'(bus.run), 32'(er));
            chk("model_step", 32'(bus.step), 32'(es));
`ifdef SRC_CU_ILLEGAL_TRAP_EN
            chk("model_illegal", 32'(bus.illegal), 32'(m_ill));
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic go_step(input logic [2:0] n);
        int k;
        k = 0;
        while (!(bus.run === 1'b1 && bus.step === n) && k < 40) begin
            tick();
            k++;
        end
        if (k >= 40) chk("timeout_step", 32'(bus.step), 32'(n));
    endtask

    initial begin
        bus.opcode = 5'd0; bus.start = 1'b0; bus.con = 1'b0; bus.mem_done = 1'b0;
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("reset_run", 32'(bus.run), 32'd0);
        chk("reset_ctrl", 32'(bus.ctrl), 32'd0);
        chk("reset_step", 32'(bus.step), 32'd0);

        // add with zero-wait memory
        bus.opcode = 5'd12; bus.mem_done = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t0_ctrl", 32'(bus.ctrl), 32'h00B8_0000);
        chk("t0_run", 32'(bus.run), 32'd1);
        go_step(3'd4);
        chk("add_t4_ctrl", 32'(bus.ctrl), 32'h0008_0060);
        tick();
        chk("add_t5_ctrl", 32'(bus.ctrl), 32'h0004_0110);
        tick();
        chk("add_back_t0", 32'(bus.step), 32'd0);

        // ld with four wait cycles in T6
        bus.opcode = 5'd1;
        go_step(3'd5);
        bus.mem_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ld_t6_step", 32'(bus.step), 32'd6);
            chk("ld_t6_ctrl", 32'(bus.ctrl), 32'h0001_4000);
            if (i == 3) bus.mem_done = 1'b1;
        end
        tick();
        chk("ld_t7_step", 32'(bus.step), 32'd7);
        chk("ld_t7_ctrl", 32'(bus.ctrl), 32'h0000_2110);
        tick();

        // br, not taken then taken
        bus.opcode = 5'd8; bus.con = 1'b0;
        go_step(3'd4);
        chk("br_nt_pcin", 32'(bus.ctrl.PCin), 32'd0);
        tick();
        bus.con = 1'b1;
        go_step(3'd4);
        chk("br_t_pcin", 32'(bus.ctrl.PCin), 32'd1);
        tick();

        // stop, restart, undefined opcode
        bus.opcode = 5'd31;
        go_step(3'd3);
        tick();
        chk("stop_run", 32'(bus.run), 32'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("restart_run", 32'(bus.run), 32'd1);
        bus.opcode = 5'd7;
        go_step(3'd3);
        tick();
`ifdef SRC_CU_ILLEGAL_TRAP_EN
        chk("undef_run", 32'(bus.run), 32'd0);
        chk("undef_illegal", 32'(bus.illegal), 32'd1);
`else
        chk("undef_run", 32'(bus.run), 32'd1);
        chk("undef_step", 32'(bus.step), 32'd0);
`endif

        // reset during T6 of st
        bus.opcode = 5'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        go_step(3'd6);
        rst = 1'b0;
        #1;
        chk("rst_async_ctrl", 32'(bus.ctrl), 32'd0);
        chk("rst_async_run", 32'(bus.run), 32'd0);
        tick();
        rst = 1'b1;

        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            tick();
            bus.mem_done = ($urandom_range(0, 2) == 0);
            bus.con      = 1'($urandom_range(0, 1));
            bus.start    = ($urandom_range(0, 3) == 0);
            if (m_halted || (m_q.size() > 0 && m_q[0].step == 0))
                bus.opcode = ops[$urandom_range(0, 13)];
        end
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
